led_fade_master: RTL and testbench
==================================

Name: led_fade_master

Overview:
- Avalon-MM master that drives the red, green and blue 8-bit LED PIO slaves, which are write-only from its side.
- On a start request it fades the current RGB colour toward a target colour, one LSB per channel per step.
- Each step issues three single-word writes (R, G, then B) to the PIO data registers.
- Sits in SysForLed between the control logic and the existing PIO output slaves, replacing per-write software pokes.

Parameters:
- RED_BASE, 32'h0000_0000, byte address of the red PIO data register (offset 0).
- GREEN_BASE, 32'h0000_0010, byte address of the green PIO data register.
- BLUE_BASE, 32'h0000_0020, byte address of the blue PIO data register.
- STEP_CYCLES, 1000, clk cycles between the start of consecutive write passes; legal range 4..65535.
- TIMEOUT_CYCLES, 255, maximum cycles waitrequest may stay high per write; used only with the optional feature.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; loads target_rgb.
- target_rgb  in  24  target colour: [23:16] R, [15:8] G, [7:0] B.
- cur_rgb  out  24  colour most recently written to all three PIOs; same packing as target_rgb.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse when cur_rgb equals the target.
- err  out  1  sticky timeout flag; cleared by reset or start.
- avm_address  out  32  byte address.
- avm_write  out  1  write request.
- avm_writedata  out  32  {24'b0, channel byte}.
- avm_byteenable  out  4  constant 4'b0001 while avm_write is high; 4'b0000 otherwise.
- avm_waitrequest  in  1  slave stall.

Behaviour:
- Reset (synchronous, active-high), applied in any state:
  - All outputs go to 0 and the FSM goes to IDLE.
  - An in-flight write is dropped: avm_write goes low on the next edge.
- FSM states: IDLE, WAIT_TICK, WR_R, WR_G, WR_B, EVAL.
- IDLE:
  - On start, latch target_rgb into tgt, set busy=1, clear err, clear tick_cnt, and go to WR_R.
  - The first pass is issued immediately, with no tick wait.
- Channel stepping:
  - At entry to WR_R the next values are computed per channel: nxt = cur+1 if cur<tgt, cur-1 if cur>tgt, else cur.
  - Unsigned 8-bit arithmetic; no wrap is possible because stepping stops at the target.
- Write states WR_R, WR_G, WR_B:
  - Drive avm_write=1 with the corresponding address and nxt byte.
  - Hold address, writedata and write stable while avm_waitrequest=1.
  - The transfer completes on the first rising edge with avm_write=1 and avm_waitrequest=0, then advance to the next state.
  - With waitrequest tied low, each write takes exactly 1 cycle, so a pass is 3 consecutive cycles.
- cur_rgb is updated to nxt in the cycle after the WR_B transfer completes (state EVAL). It is never updated for a partial pass.
- EVAL:
  - If cur_rgb==tgt: pulse done for one cycle, set busy=0, go to IDLE.
  - Otherwise go to WAIT_TICK.
- Tick counter:
  - tick_cnt counts from the cycle the pass enters WR_R.
  - WAIT_TICK exits to WR_R when tick_cnt reaches STEP_CYCLES-1.
  - If a pass stalls longer than STEP_CYCLES, WR_R is entered in the cycle after EVAL.
- start while busy:
  - The new target_rgb is latched into tgt immediately.
  - The current pass completes unchanged; the next pass steps toward the new target.
  - busy stays high and no done is issued for the old target.
- start with target equal to cur_rgb: one full 3-write pass of unchanged values is issued (resyncs the PIOs), then done.
- Maximum fade is 255 passes.
- start and done can never coincide; start in the EVAL cycle is handled as start while busy.

Optional Feature:
- Macro: LED_FADE_TIMEOUT_EN.
- Defined:
  - A per-write counter runs while avm_waitrequest=1.
  - If the counter reaches TIMEOUT_CYCLES, deassert avm_write, set err=1, pulse done, set busy=0, and return to IDLE.
  - cur_rgb is left at its last completed pass.
- Not defined: no counter is built, err is tied to 0, and the master waits indefinitely on waitrequest.

Test Plan:
- Reset, then start with target 24'h03_00_01 from cur 0, STEP_CYCLES=4, waitrequest=0:
  - Passes write (R,G,B) = (1,0,1), (2,0,1), (3,0,1) at addresses 0x00, 0x10, 0x20.
  - Passes start 4 cycles apart.
  - done pulses once, cur_rgb=24'h030001, busy low.
- From cur 24'h030001, start with target 24'h000001:
  - R steps down 2, 1, 0 while G and B hold.
  - No wrap below 0; exactly 3 passes.
- Start with target equal to cur:
  - Exactly 3 writes are issued.
  - done follows 1 cycle after the WR_B transfer.
- Hold waitrequest high for 7 cycles on the WR_G write:
  - Address 0x10 and writedata stay stable.
  - cur_rgb is not updated until WR_B completes.
  - The next pass starts right after EVAL if the tick has already elapsed.
- Start 24'hFF0000, then start 24'h000000 after 2 passes:
  - R returns 2 → 1 → 0.
  - A single done pulse occurs at the end.
- With LED_FADE_TIMEOUT_EN and TIMEOUT_CYCLES=8, hold waitrequest high forever:
  - avm_write drops after 8 stall cycles; err=1; done pulse.
  - Reset mid-stall instead clears everything on the next edge.

Source files
------------

// File: rtl/led_fade_master.sv
// Avalon-MM master that fades the RGB LED PIOs one LSB per channel per pass toward a target colour.
// Optional write-stall timeout is built when LED_FADE_TIMEOUT_EN is defined.
module led_fade_master #(
  parameter logic [31:0] RED_BASE       = 32'h0000_0000,
  parameter logic [31:0] GREEN_BASE     = 32'h0000_0010,
  parameter logic [31:0] BLUE_BASE      = 32'h0000_0020,
  parameter int          STEP_CYCLES    = 1000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] target_rgb,
  output logic [23:0] cur_rgb,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest
);

  // Handshake: a write transfers on a rising edge where avm_write=1 and
  // avm_waitrequest=0; while stalled, address, data and write are held.

  typedef enum logic [2:0] {IDLE, WAIT_TICK, WR_R, WR_G, WR_B, EVAL} state_t;

  localparam logic [15:0] TICK_LAST = 16'(STEP_CYCLES - 1);

  state_t      state, state_nxt;
  logic [23:0] tgt;
  logic [23:0] nxt;
  logic [23:0] eff_tgt;
  logic [23:0] step_val;
  logic [15:0] tick_cnt;
  logic        xfer;
  logic        tick_due;
  logic        enter_wr;
  logic        eval_done;
  logic        timeout_hit;

  function automatic logic [7:0] step8(input logic [7:0] c, input logic [7:0] t);
    if (c < t) return c + 8'd1;
    if (c > t) return c - 8'd1;
    return c;
  endfunction

  // A start coinciding with pass entry already steers that pass.
  assign eff_tgt  = start ? target_rgb : tgt;
  assign step_val = {step8(cur_rgb[23:16], eff_tgt[23:16]),
                     step8(cur_rgb[15:8],  eff_tgt[15:8]),
                     step8(cur_rgb[7:0],   eff_tgt[7:0])};
  assign xfer     = avm_write && !avm_waitrequest;
  assign tick_due = tick_cnt >= TICK_LAST;
  assign enter_wr = (state_nxt == WR_R) && (state != WR_R);
  assign done     = eval_done || timeout_hit;

  always_comb begin
    state_nxt = state;
    eval_done = 1'b0;
    case (state)
      IDLE:      if (start) state_nxt = WR_R;
      WAIT_TICK: if (tick_due) state_nxt = WR_R;
      WR_R:      if (xfer) state_nxt = WR_G;
      WR_G:      if (xfer) state_nxt = WR_B;
      WR_B:      if (xfer) state_nxt = EVAL;
      EVAL: begin
        if (!start && cur_rgb == tgt) begin
          eval_done = 1'b1;
          state_nxt = IDLE;
        end else if (tick_due) begin
          state_nxt = WR_R;
        end else begin
          state_nxt = WAIT_TICK;
        end
      end
      default:   state_nxt = IDLE;
    endcase
    if (timeout_hit) state_nxt = IDLE;
  end

  always_comb begin
    avm_write      = 1'b0;
    avm_address    = 32'h0;
    avm_writedata  = 32'h0;
    avm_byteenable = 4'b0000;
    case (state)
      WR_R: begin
        avm_write     = 1'b1;
        avm_address   = RED_BASE;
        avm_writedata = {24'h0, nxt[23:16]};
      end
      WR_G: begin
        avm_write     = 1'b1;
        avm_address   = GREEN_BASE;
        avm_writedata = {24'h0, nxt[15:8]};
      end
      WR_B: begin
        avm_write     = 1'b1;
        avm_address   = BLUE_BASE;
        avm_writedata = {24'h0, nxt[7:0]};
      end
      default: ;
    endcase
    if (avm_write) avm_byteenable = 4'b0001;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tgt      <= 24'h0;
      nxt      <= 24'h0;
      cur_rgb  <= 24'h0;
      busy     <= 1'b0;
      tick_cnt <= 16'h0;
    end else begin
      state <= state_nxt;
      if (start) tgt <= target_rgb;
      if (enter_wr) begin
        nxt      <= step_val;
        tick_cnt <= 16'h0;
      end else if (tick_cnt != 16'hFFFF) begin
        tick_cnt <= tick_cnt + 16'd1;
      end
      // cur_rgb only moves once the whole pass has landed in the PIOs.
      if (state == WR_B && xfer) cur_rgb <= nxt;
      if (state == IDLE && start) busy <= 1'b1;
      else if (state != IDLE && state_nxt == IDLE) busy <= 1'b0;
    end
  end

`ifdef LED_FADE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;
  logic        err_q;

  assign timeout_hit = avm_write && avm_waitrequest && (wait_cnt == TO_LAST);
  assign err         = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 16'h0;
      err_q    <= 1'b0;
    end else begin
      if (avm_write && avm_waitrequest) wait_cnt <= wait_cnt + 16'd1;
      else wait_cnt <= 16'h0;
      if (timeout_hit) err_q <= 1'b1;
      else if (start) err_q <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_led_fade_master.sv
// Bench for led_fade_master: transaction-level fade model, per-cycle monitor and scoreboard.
// Define LED_FADE_TIMEOUT_EN in both files to also exercise the stall timeout.
module tb_led_fade_master;

  localparam int          STEP = 4;
  localparam int          TO   = 8;
  localparam logic [31:0] RB   = 32'h0000_0000;
  localparam logic [31:0] GB   = 32'h0000_0010;
  localparam logic [31:0] BB   = 32'h0000_0020;
  localparam int          W    = 40;

  logic        clk;
  logic        reset;
  logic        start;
  logic [23:0] target_rgb;
  logic [23:0] cur_rgb;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;

  led_fade_master #(
    .RED_BASE(RB), .GREEN_BASE(GB), .BLUE_BASE(BB),
    .STEP_CYCLES(STEP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .target_rgb(target_rgb),
    .cur_rgb(cur_rgb), .busy(busy), .done(done), .err(err),
    .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters / scoreboard ----------------
  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] exp_q[$];
  logic [23:0]  exp_done_q[$];
  int           done_exp  = 0;
  int           done_seen = 0;
  int           xfer_cnt  = 0;
  int           pass_starts[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [23:0] model_cur;

  function automatic int npass(input logic [23:0] c, input logic [23:0] t);
    int m = 1;
    for (int ch = 0; ch < 3; ch++) begin
      int d = int'(c[ch*8 +: 8]) - int'(t[ch*8 +: 8]);
      if (d < 0) d = -d;
      if (d > m) m = d;
    end
    return m;
  endfunction

  task automatic model_pass(input logic [23:0] t);
    logic [23:0] n;
    for (int ch = 0; ch < 3; ch++) begin
      int c  = int'(model_cur[ch*8 +: 8]);
      int tt = int'(t[ch*8 +: 8]);
      if (c < tt) c = c + 1;
      else if (c > tt) c = c - 1;
      n[ch*8 +: 8] = 8'(c);
    end
    exp_q.push_back({RB, n[23:16]});
    exp_q.push_back({GB, n[15:8]});
    exp_q.push_back({BB, n[7:0]});
    model_cur = n;
  endtask

  task automatic model_fade(input logic [23:0] t);
    int n = npass(model_cur, t);
    repeat (n) model_pass(t);
    exp_done_q.push_back(t);
    done_exp++;
  endtask

  // ---------------- waitrequest generator ----------------
  bit stall_mode = 0;
  bit stall_hold = 0;
  bit arm_g      = 0;
  int force_cnt  = 0;

  initial begin
    avm_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (arm_g && avm_write && avm_address == GB) begin
        force_cnt = 7;
        arm_g     = 0;
      end
      if (stall_hold) begin
        avm_waitrequest = 1'b1;
      end else if (force_cnt > 0) begin
        avm_waitrequest = 1'b1;
        force_cnt--;
      end else if (stall_mode) begin
        avm_waitrequest = ($urandom_range(0, 3) == 0);
      end else begin
        avm_waitrequest = 1'b0;
      end
    end
  end

  // ---------------- monitor / compare ----------------
  bit          mon_en = 1;
  logic        prev_write, prev_wait;
  logic [31:0] prev_addr, prev_data;
  logic [23:0] prev_cur, pass_val;
  int          last_b = -100, pass_s = 0, exp_start = 0;
  bit          have_exp = 0, chk_busy_low = 0;

  always @(negedge clk) begin
    if (reset || !mon_en) begin
      prev_write   = 1'b0;
      prev_wait    = 1'b0;
      prev_cur     = cur_rgb;
      last_b       = -100;
      have_exp     = 0;
      chk_busy_low = 0;
    end else begin
      chk("byteenable", W'(avm_byteenable), W'(avm_write ? 4'b0001 : 4'b0000));
      chk("err_idle", W'(err), W'(0));
      if (chk_busy_low) begin
        chk("busy_after_done", W'(busy), W'(0));
        chk_busy_low = 0;
      end
      if (start && !busy) begin
        exp_start = cyc + 1;
        have_exp  = 1;
      end
      if (prev_write && prev_wait) begin
        chk("stall_write", W'(avm_write), W'(1));
        chk("stall_addr", W'(avm_address), W'(prev_addr));
        chk("stall_data", W'(avm_writedata), W'(prev_data));
      end
      if (avm_write && !prev_write && avm_address == RB) begin
        if (have_exp) chk("pass_start_cycle", W'(cyc), W'(exp_start));
        else begin
          mismatched++;
          $display("FAIL unexpected_pass: pass began at cycle %0d, none required", cyc);
        end
        have_exp = 0;
        pass_s   = cyc;
        pass_starts.push_back(cyc);
      end
      if (avm_write && !avm_waitrequest) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write required", avm_address, avm_writedata);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          compared++;
          chk("write_addr", W'(avm_address), W'(e[39:8]));
          compared--;
          chk("write_data", W'(avm_writedata), W'({24'h0, e[7:0]}));
          if (e[39:8] == RB) pass_val[23:16] = e[7:0];
          else if (e[39:8] == GB) pass_val[15:8] = e[7:0];
          else pass_val[7:0] = e[7:0];
        end
        if (avm_address == BB) begin
          last_b    = cyc;
          exp_start = (pass_s + STEP > cyc + 2) ? pass_s + STEP : cyc + 2;
          have_exp  = 1;
        end
      end
      if (cyc == last_b + 1) chk("cur_update", W'(cur_rgb), W'(pass_val));
      else chk("cur_hold", W'(cur_rgb), W'(prev_cur));
      if (done) begin
        done_seen++;
        if (cyc != last_b + 1 || exp_done_q.size() == 0) begin
          mismatched++;
          $display("FAIL done_spurious: done at cycle %0d, last pass end %0d", cyc, last_b);
        end else begin
          chk("done_value", W'(cur_rgb), W'(exp_done_q.pop_front()));
        end
        chk_busy_low = 1;
      end
      prev_write = avm_write;
      prev_wait  = avm_waitrequest;
      prev_addr  = avm_address;
      prev_data  = avm_writedata;
      prev_cur   = cur_rgb;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_now(input logic [23:0] t);
    #1;
    start      = 1'b1;
    target_rgb = t;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_start(input logic [23:0] t);
    @(posedge clk);
    start_now(t);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 20000);
    if (busy) begin
      mismatched++;
      $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_xfers(input int m);
    int n = 0;
    while (xfer_cnt < m && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (xfer_cnt < m) begin
      mismatched++;
      $display("FAIL xfer_timeout: saw %0d writes, required %0d", xfer_cnt, m);
    end
  endtask

  int xb, pb;

  task automatic fade(input logic [23:0] t);
    model_fade(t);
    xb = xfer_cnt;
    pb = pass_starts.size();
    do_start(t);
    wait_idle();
  endtask

  task automatic fade_retarget(input logic [23:0] t1, input int k, input logic [23:0] t2);
    repeat (k) model_pass(t1);
    model_fade(t2);
    xb = xfer_cnt;
    pb = pass_starts.size();
    do_start(t1);
    wait_xfers(xb + 3 * k);
    start_now(t2);
    wait_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    target_rgb = 24'h0;
    model_cur  = 24'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cur", W'(cur_rgb), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_err", W'(err), W'(0));
    chk("rst_write", W'(avm_write), W'(0));
    chk("rst_addr", W'(avm_address), W'(0));
    chk("rst_data", W'(avm_writedata), W'(0));
    chk("rst_be", W'(avm_byteenable), W'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    fade(24'h030001);
    chk("pin1_cur", W'(cur_rgb), W'(24'h030001));
    chk("pin1_model", W'(model_cur), W'(24'h030001));
    chk("pin1_writes", W'(xfer_cnt - xb), W'(9));
    chk("pin1_passes", W'(pass_starts.size() - pb), W'(3));
    if (pass_starts.size() - pb == 3) begin
      chk("pin1_gap0", W'(pass_starts[pb+1] - pass_starts[pb]), W'(4));
      chk("pin1_gap1", W'(pass_starts[pb+2] - pass_starts[pb+1]), W'(4));
    end

    fade(24'h000001);
    chk("pin2_cur", W'(cur_rgb), W'(24'h000001));
    chk("pin2_writes", W'(xfer_cnt - xb), W'(9));

    fade(24'h000001);
    chk("pin3_writes", W'(xfer_cnt - xb), W'(3));
    chk("pin3_cur", W'(cur_rgb), W'(24'h000001));

    arm_g = 1;
    fade(24'h000003);
    chk("pin4_cur", W'(cur_rgb), W'(24'h000003));
    chk("pin4_writes", W'(xfer_cnt - xb), W'(6));
    if (pass_starts.size() - pb == 2)
      chk("pin4_gap", W'(pass_starts[pb+1] - pass_starts[pb]), W'(11));
    else chk("pin4_passes", W'(pass_starts.size() - pb), W'(2));

    fade(24'h000000);
    chk("pin5_writes", W'(xfer_cnt - xb), W'(9));

    fade_retarget(24'hFF0000, 2, 24'h000000);
    chk("pin6_cur", W'(cur_rgb), W'(24'h000000));
    chk("pin6_writes", W'(xfer_cnt - xb), W'(12));
    chk("pin6_dones", W'(done_seen), W'(6));

    stall_mode = 1;
    for (int i = 0; i < 8; i++) begin
      logic [23:0] t1, t2;
      int np;
      t1 = 24'($urandom);
      t2 = 24'($urandom);
      np = npass(model_cur, t1);
      if ($urandom_range(0, 1) == 1 && np > 1) fade_retarget(t1, $urandom_range(1, np - 1), t2);
      else fade(t1);
      chk("rand_cur", W'(cur_rgb), W'(model_cur));
    end
    stall_mode = 0;

    chk("left_writes", W'(exp_q.size()), W'(0));
    chk("left_dones", W'(exp_done_q.size()), W'(0));
    chk("done_count", W'(done_seen), W'(done_exp));

`ifdef LED_FADE_TIMEOUT_EN
    begin
      int n = 0, wc = 0;
      mon_en     = 0;
      stall_hold = 1;
      do_start(24'h010101);
      while (n < 50) begin
        @(negedge clk);
        n++;
        if (avm_write) wc++;
        if (done) break;
      end
      chk("to_done", W'(done), W'(1));
      chk("to_write_cycles", W'(wc), W'(TO));
      @(negedge clk);
      chk("to_write_low", W'(avm_write), W'(0));
      chk("to_err", W'(err), W'(1));
      chk("to_busy", W'(busy), W'(0));
      do_start(24'h010101);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_stall_write", W'(avm_write), W'(0));
      chk("rst_stall_busy", W'(busy), W'(0));
      chk("rst_stall_err", W'(err), W'(0));
      @(posedge clk);
      #1 reset = 1'b0;
      stall_hold = 0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
